// File: rtl/pll_reconfig_ctrl.sv
// Reset/lock sequencer for the Gowin rPLL dynamic dividers: applies divider codes,
// pulses PLL RESET, waits for lock with timeout/retry and qualifies lock stability.
module pll_reconfig_ctrl #(
   parameter int         RST_CYCLES   = 16,
   parameter int         LOCK_TIMEOUT = 27000,
   parameter int         LOCK_STABLE  = 256,
   parameter int         MAX_RETRY    = 3,
   parameter logic [5:0] INIT_IDSEL   = 6'd0,
   parameter logic [5:0] INIT_FBDSEL  = 6'd0,
   parameter logic [5:0] INIT_ODSEL   = 6'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_req,
   input  logic [5:0] cfg_idsel,
   input  logic [5:0] cfg_fbdsel,
   input  logic [5:0] cfg_odsel,
   output logic       cfg_ack,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] pll_idsel,
   output logic [5:0] pll_fbdsel,
   output logic [5:0] pll_odsel,
   output logic       clk_ok,
   output logic       busy,
   output logic       fail
);

   localparam int TMR_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int TMR_MAX  = (TMR_MAX0 > LOCK_STABLE) ? TMR_MAX0 : LOCK_STABLE;
   localparam int TW       = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int RW       = $clog2(MAX_RETRY + 1);

   localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STB_LAST  = TW'(LOCK_STABLE - 1);
   localparam logic [RW-1:0] RTRY_LAST = RW'(MAX_RETRY - 1);

   typedef enum logic [2:0] {
      ST_RST_PLL   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [5:0]    idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
   logic          ack_q, ack_d;
   logic          pll_reset_q, pll_reset_d;
   logic          clk_ok_q, clk_ok_d;
   logic          busy_q, busy_d;
   logic          fail_q, fail_d;
   logic          lock_meta_q, lock_sync_q;

   // Two-flop synchronizer for the asynchronous PLL LOCK
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= pll_lock;
         lock_sync_q <= lock_meta_q;
      end
   end

   // Next-state, counters and registered-output values
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      retry_d  = retry_q;
      idsel_d  = idsel_q;
      fbdsel_d = fbdsel_q;
      odsel_d  = odsel_q;
      ack_d    = 1'b0;

      case (state_q)
         ST_RST_PLL: begin
            if (timer_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_sync_q) begin
               state_d = ST_STABLE;
               timer_d = '0;
            end else if (timer_q == TO_LAST) begin
               timer_d = '0;
               retry_d = retry_q + RW'(1);
               if (retry_q == RTRY_LAST) begin
                  state_d = ST_FAIL;
               end else begin
                  state_d = ST_RST_PLL;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_STABLE: begin
            // A lock drop restarts the lock wait without consuming a retry
            if (!lock_sync_q) begin
               state_d = ST_WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == STB_LAST) begin
               state_d = ST_RUN;
               timer_d = '0;
               retry_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_RUN, ST_FAIL: begin
            // A request beats a simultaneous lock loss so the requester always gets its ack
            if (cfg_req) begin
               state_d  = ST_RST_PLL;
               timer_d  = '0;
               retry_d  = '0;
               idsel_d  = cfg_idsel;
               fbdsel_d = cfg_fbdsel;
               odsel_d  = cfg_odsel;
               ack_d    = 1'b1;
            end else if (state_q == ST_RUN && !lock_sync_q) begin
               state_d = ST_RST_PLL;
               timer_d = '0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_RST_PLL;
            timer_d = '0;
         end
      endcase

      pll_reset_d = (state_d == ST_RST_PLL);
      clk_ok_d    = (state_d == ST_RUN);
      busy_d      = (state_d != ST_RUN) && (state_d != ST_FAIL);
      fail_d      = (state_d == ST_FAIL);
   end

   // State, counters and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RST_PLL;
         timer_q     <= '0;
         retry_q     <= '0;
         idsel_q     <= INIT_IDSEL;
         fbdsel_q    <= INIT_FBDSEL;
         odsel_q     <= INIT_ODSEL;
         ack_q       <= 1'b0;
         pll_reset_q <= 1'b1;
         clk_ok_q    <= 1'b0;
         busy_q      <= 1'b1;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         idsel_q     <= idsel_d;
         fbdsel_q    <= fbdsel_d;
         odsel_q     <= odsel_d;
         ack_q       <= ack_d;
         pll_reset_q <= pll_reset_d;
         clk_ok_q    <= clk_ok_d;
         busy_q      <= busy_d;
         fail_q      <= fail_d;
      end
   end

   assign cfg_ack    = ack_q;
   assign pll_reset  = pll_reset_q;
   assign pll_idsel  = idsel_q;
   assign pll_fbdsel = fbdsel_q;
   assign pll_odsel  = odsel_q;
   assign clk_ok     = clk_ok_q;
   assign busy       = busy_q;
   assign fail       = fail_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed-plus-random bench for pll_reconfig_ctrl; expected timings come from
// the sequencing rules expressed as cycle arithmetic, expected codes from a code model.
module tb_pll_reconfig_ctrl;

   localparam int         RST_CYCLES   = 4;
   localparam int         LOCK_TIMEOUT = 50;
   localparam int         LOCK_STABLE  = 8;
   localparam int         MAX_RETRY    = 3;
   localparam logic [5:0] INIT_ID      = 6'h05;
   localparam logic [5:0] INIT_FB      = 6'h0A;
   localparam logic [5:0] INIT_OD      = 6'h01;

   // Ticks from raising pll_lock until clk_ok: the sampling edge, then LOCK_STABLE+2 edges
   localparam int QUAL_LAT = 1 + LOCK_STABLE + 2;
   // Ticks from dropping pll_lock in RUN until clk_ok falls: two sync edges plus one
   localparam int LOSS_LAT = 3;
   localparam int FAIL_LAT = LOSS_LAT + MAX_RETRY * (RST_CYCLES + LOCK_TIMEOUT);

   logic       clk = 1'b0;
   logic       rst_n, cfg_req, pll_lock;
   logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
   logic       cfg_ack, pll_reset, clk_ok, busy, fail;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;

   int         total = 0;
   int         bad   = 0;
   logic [5:0] exp_id, exp_fb, exp_od;

   pll_reconfig_ctrl #(
      .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE),
      .MAX_RETRY(MAX_RETRY), .INIT_IDSEL(INIT_ID), .INIT_FBDSEL(INIT_FB), .INIT_ODSEL(INIT_OD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req),
      .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
      .cfg_ack(cfg_ack), .pll_lock(pll_lock), .pll_reset(pll_reset),
      .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
      .clk_ok(clk_ok), .busy(busy), .fail(fail)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return pll_reset;
         1:       return clk_ok;
         2:       return fail;
         default: return cfg_ack;
      endcase
   endfunction

   // Ticks until the selected output reaches val; limit+1 means it never did
   task automatic wait_for(input int which, input logic val, input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (sig(which) !== val && n <= limit);
   endtask

   task automatic chk_codes(input string tag);
      chk({tag, "_idsel"}, pll_idsel, exp_id);
      chk({tag, "_fbdsel"}, pll_fbdsel, exp_fb);
      chk({tag, "_odsel"}, pll_odsel, exp_od);
   endtask

   // Issue a request from RUN or FAIL; the emulated PLL drops lock once reset
   task automatic apply_cfg(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
      int n;
      cfg_idsel = i; cfg_fbdsel = f; cfg_odsel = o; cfg_req = 1'b1;
      tick();
      exp_id = i; exp_fb = f; exp_od = o;
      chk("cfg_ack_pulse", cfg_ack, 1'b1);
      chk("cfg_reset_rise", pll_reset, 1'b1);
      chk_codes("cfg_codes");
      chk("cfg_clk_ok_low", clk_ok, 1'b0);
      chk("cfg_busy", busy, 1'b1);
      chk("cfg_fail_clear", fail, 1'b0);
      cfg_req = 1'b0;
      pll_lock = 1'b0;
      tick();
      chk("cfg_ack_once", cfg_ack, 1'b0);
      wait_for(0, 1'b0, 100, n);
      chk("cfg_reset_width", n + 1, RST_CYCLES);
   endtask

   task automatic qualify(input int dly);
      int n;
      repeat (dly) tick();
      chk("qual_clk_ok_before", clk_ok, 1'b0);
      pll_lock = 1'b1;
      wait_for(1, 1'b1, 500, n);
      chk("qual_latency", n, QUAL_LAT);
      chk("qual_busy_low", busy, 1'b0);
   endtask

   initial begin
      int n, pulses, early;
      logic prev;
      logic [5:0] b_id, b_fb, b_od;

      rst_n = 1'b0; cfg_req = 1'b0; pll_lock = 1'b0;
      cfg_idsel = 6'd0; cfg_fbdsel = 6'd0; cfg_odsel = 6'd0;
      exp_id = INIT_ID; exp_fb = INIT_FB; exp_od = INIT_OD;
      #12;
      chk("rst_pll_reset", pll_reset, 1'b1);
      chk_codes("rst");
      chk("rst_clk_ok", clk_ok, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_fail", fail, 1'b0);
      chk("rst_ack", cfg_ack, 1'b0);

      // Power-up
      @(negedge clk);
      rst_n = 1'b1;
      wait_for(0, 1'b0, 100, n);
      chk("pwrup_reset_width", n, RST_CYCLES);
      chk_codes("pwrup");
      qualify(10);

      // Reconfiguration, fixed then random codes
      apply_cfg(6'h12, 6'h34, 6'h3E);
      qualify($urandom_range(0, 30));
      for (int k = 0; k < 3; k++) begin
         apply_cfg(6'($urandom), 6'($urandom), 6'($urandom));
         qualify($urandom_range(0, 30));
      end

      // Lock loss in RUN, then a glitch during qualification
      pll_lock = 1'b0;
      wait_for(1, 1'b0, 20, n);
      chk("loss_latency", n, LOSS_LAT);
      chk("loss_reset", pll_reset, 1'b1);
      chk_codes("loss");
      wait_for(0, 1'b0, 100, n);
      chk("loss_reset_width", n, RST_CYCLES);
      repeat ($urandom_range(0, 20)) tick();
      pll_lock = 1'b1;
      repeat (6) tick();
      pll_lock = 1'b0;
      repeat (3) tick();
      chk("glitch_clk_ok", clk_ok, 1'b0);
      chk("glitch_busy", busy, 1'b1);
      pll_lock = 1'b1;
      wait_for(1, 1'b1, 500, n);
      chk("glitch_requal", n, QUAL_LAT);

      // Timeouts until FAIL
      pll_lock = 1'b0;
      pulses = 0; n = 0; prev = pll_reset;
      do begin
         tick(); n++;
         if (pll_reset && !prev) pulses++;
         prev = pll_reset;
      end while (!fail && n < 1000);
      chk("fail_latency", n, FAIL_LAT);
      chk("fail_pulses", pulses, MAX_RETRY);
      repeat (5) tick();
      chk("fail_hold", fail, 1'b1);
      chk("fail_pll_reset", pll_reset, 1'b0);
      chk("fail_clk_ok", clk_ok, 1'b0);
      chk("fail_busy", busy, 1'b0);

      // Exit FAIL; one timeout, then a STABLE glitch must not consume a retry
      apply_cfg(6'($urandom), 6'($urandom), 6'($urandom));
      wait_for(0, 1'b1, 200, n);
      chk("timeout_len", n, LOCK_TIMEOUT);
      wait_for(0, 1'b0, 100, n);
      chk("retry_reset_width", n, RST_CYCLES);
      pll_lock = 1'b1;
      repeat (6) tick();
      pll_lock = 1'b0;
      pulses = 0; n = 0; prev = pll_reset;
      do begin
         tick(); n++;
         if (pll_reset && !prev) pulses++;
         prev = pll_reset;
      end while (!fail && n < 1000);
      chk("glitch_retry_pulses", pulses, 1);
      chk("glitch_retry_latency", n, LOSS_LAT + 2 * LOCK_TIMEOUT + RST_CYCLES);
      apply_cfg(6'($urandom), 6'($urandom), 6'($urandom));
      qualify($urandom_range(0, 30));

      // Request and synchronized lock loss reach the FSM on the same edge
      pll_lock = 1'b0;
      tick(); tick();
      chk("simul_pre_clk_ok", clk_ok, 1'b1);
      cfg_idsel = 6'($urandom); cfg_fbdsel = 6'($urandom); cfg_odsel = 6'($urandom);
      cfg_req = 1'b1;
      tick();
      exp_id = cfg_idsel; exp_fb = cfg_fbdsel; exp_od = cfg_odsel;
      chk("simul_ack", cfg_ack, 1'b1);
      chk("simul_reset", pll_reset, 1'b1);
      chk_codes("simul");
      b_id = 6'($urandom); b_fb = 6'($urandom); b_od = 6'($urandom);
      cfg_idsel = b_id; cfg_fbdsel = b_fb; cfg_odsel = b_od;
      tick();
      chk("simul_ack_once", cfg_ack, 1'b0);
      chk_codes("held_codes_kept");
      wait_for(0, 1'b0, 100, n);
      chk("simul_reset_width", n + 1, RST_CYCLES);
      early = 0;
      repeat ($urandom_range(0, 20)) begin
         tick();
         if (cfg_ack) early++;
      end
      pll_lock = 1'b1;
      n = 0;
      do begin
         tick(); n++;
      end while (!cfg_ack && n < 500);
      chk("held_early_acks", early, 0);
      chk("held_ack_latency", n, QUAL_LAT + 1);
      exp_id = b_id; exp_fb = b_fb; exp_od = b_od;
      chk_codes("held");

      // Asynchronous reset during WAIT_LOCK
      cfg_req = 1'b0;
      pll_lock = 1'b0;
      wait_for(0, 1'b0, 100, n);
      chk("pre_rst_reset_width", n, RST_CYCLES);
      repeat (5) tick();
      chk("pre_rst_busy", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_id = INIT_ID; exp_fb = INIT_FB; exp_od = INIT_OD;
      chk_codes("midrst");
      chk("midrst_pll_reset", pll_reset, 1'b1);
      chk("midrst_fail", fail, 1'b0);
      chk("midrst_clk_ok", clk_ok, 1'b0);
      chk("midrst_busy", busy, 1'b1);
      chk("midrst_ack", cfg_ack, 1'b0);
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencer for the Gowin rPLL dynamic-divider path. On reset and on every reconfiguration request, it drives the PLL IDSEL/FBDSEL/ODSEL codes and pulses the PLL RESET. It then waits for LOCK with a timeout and retries, and qualifies lock stability before asserting `clk_ok`. `clk_ok` gates the derived-clock FIFO side's reset release. The block runs on the 27 MHz board clock that also feeds the PLL CLKIN.

## Interface
Parameters:
- `RST_CYCLES`, default 16: cycles PLL RESET is held high per attempt (≥1).
- `LOCK_TIMEOUT`, default 27000: cycles to wait for lock per attempt (1 ms at 27 MHz).
- `LOCK_STABLE`, default 256: consecutive synchronized-lock cycles required before `clk_ok`.
- `MAX_RETRY`, default 3: consecutive timeouts that force FAIL (≥1).
- `INIT_IDSEL` / `INIT_FBDSEL` / `INIT_ODSEL`, default 6'd0: codes driven out of reset, passed to the PLL unmodified.

Ports:
- `clk` in 1: 27 MHz controller clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_req` in 1: request to apply new codes; level, held by the requester until `cfg_ack`.
- `cfg_idsel`, `cfg_fbdsel`, `cfg_odsel` in 6 each: new codes, sampled when the request is accepted.
- `cfg_ack` out 1: one-cycle pulse, request accepted.
- `pll_lock` in 1: PLL LOCK, asynchronous to `clk`.
- `pll_reset` out 1: to PLL RESET.
- `pll_idsel`, `pll_fbdsel`, `pll_odsel` out 6 each: to the PLL dynamic select ports.
- `clk_ok` out 1: PLL output qualified stable.
- `busy` out 1: sequencing in progress; high when not in RUN or FAIL.
- `fail` out 1: retry budget exhausted.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`. Only `lock_s` is used internally.
- States: RST_PLL, WAIT_LOCK, STABLE, RUN, FAIL. All outputs are registered.
- Reset values:
  - state RST_PLL, timer 0, retry 0.
  - `pll_reset`=1.
  - `pll_*sel`=INIT_*.
  - `clk_ok`=0, `busy`=1, `fail`=0, `cfg_ack`=0.
- RST_PLL: `pll_reset`=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK: `pll_reset`=0.
  - `lock_s`=1: go to STABLE with the counter cleared.
  - Timer reaches LOCK_TIMEOUT-1 without lock: increment retry. If retry reaches MAX_RETRY, go to FAIL; otherwise go to RST_PLL.
- STABLE: count consecutive `lock_s`=1 cycles.
  - Count reaches LOCK_STABLE-1: go to RUN and clear retry.
  - `lock_s`=0 at any point: return to WAIT_LOCK with a fresh timer. Retry is not incremented.
- RUN: `clk_ok`=1, `busy`=0.
  - `cfg_req`=1: latch the cfg codes into `pll_*sel`, pulse `cfg_ack`, go to RST_PLL.
  - `lock_s`=0: go to RST_PLL with codes unchanged.
  - Both in the same cycle: `cfg_req` wins, i.e. new codes are applied and `cfg_ack` pulses.
- FAIL: `fail`=1, `pll_reset`=0, `clk_ok`=0, `busy`=0. Exit only via `cfg_req`, which is accepted as in RUN and also clears retry and `fail`, or via `rst_n`.
- `cfg_req` in RST_PLL, WAIT_LOCK or STABLE is ignored with no ack. The requester keeps holding it, and it is served on entry to RUN/FAIL.
- `pll_*sel` change only in the cycle that `pll_reset` rises, so codes are never changed while the PLL is out of reset.
- Counter widths are `$clog2` of the largest parameter they compare against. No wrap is possible because every counter is cleared on state entry.

## Timing
- After `rst_n` deasserts, `pll_reset` stays high for RST_CYCLES `clk` edges, then falls.
- `cfg_req` accepted at edge N (RUN): at N+1, `cfg_ack`=1, `pll_reset`=1, new `pll_*sel`, `clk_ok`=0, `busy`=1. `cfg_ack` is low at N+2.
- Lock loss in RUN: `lock_s` falls 2 edges after `pll_lock`. `clk_ok` falls and `pll_reset` rises on the next edge, i.e. 3 edges after `pll_lock` falls.
- Lock qualification: `clk_ok` rises LOCK_STABLE+2 edges after the first edge sampling `pll_lock` high in WAIT_LOCK.
- WAIT_LOCK lasts at most LOCK_TIMEOUT cycles per attempt.
- Asynchronous `rst_n` assertion at any state returns all outputs to their reset values immediately.

## Test plan
Parameters for the bench: RST_CYCLES=4, LOCK_TIMEOUT=50, LOCK_STABLE=8, MAX_RETRY=3.

- Power-up: release `rst_n`, raise `pll_lock` 10 cycles after `pll_reset` falls.
  - `pll_reset` high exactly 4 cycles.
  - `clk_ok` rises 10 edges after `pll_lock` is sampled high.
  - `busy` falls with it.
- Reconfig: in RUN, `cfg_req` with codes 6'h12/6'h34/6'h3E.
  - One `cfg_ack` pulse and `pll_*sel` updated in the same cycle `pll_reset` rises.
  - `clk_ok`=0 until re-qualified.
- Glitch during STABLE: drop `pll_lock` for 3 cycles after 5 stable cycles.
  - Returns to WAIT_LOCK and retry is unchanged.
  - `clk_ok` rises only after 8 fresh stable cycles.
- Timeout/fail: hold `pll_lock`=0.
  - Exactly 3 `pll_reset` pulses.
  - `fail`=1 after the third 50-cycle timeout.
  - A subsequent `cfg_req` is acked, clears `fail` and restarts RST_PLL.
- Simultaneous: `cfg_req` and `pll_lock` drop in the same RUN cycle.
  - New codes applied and `cfg_ack` pulses once.
  - `cfg_req` held high during WAIT_LOCK is not acked until RUN.
- Reset mid-operation: assert `rst_n` during WAIT_LOCK.
  - `pll_*sel`=INIT immediately, `pll_reset`=1, `fail`=0, `clk_ok`=0.
